enigma_rotor_ctrl: RTL
======================

Name: enigma_rotor_ctrl

Overview:
Sequencer for the Enigma rotor datapath. It loads the rotor A and rotor B substitution tables serially, and tracks the rotor step offset (shift_accu) plus its one-stage-delayed copy (shift_accu_pipe). It latches crypt_mode into crypt_mode_buf and steps a 2-stage character pipeline, producing the valid strobes the forward/backward rotor lookups and the output register need.

Parameters:
CODE_W, 6, width of a character code and of a rotor table entry
TBL_DEPTH, 64, entries per rotor table (2**CODE_W)
PIPE_DEPTH, 2, pipeline stages between character accept and code_valid

Ports:
clk  in  1  system clock
srst  in  1  synchronous reset, active-high
load  in  1  table-load strobe; one entry per cycle
load_idx  in  7  entry index; [6]=0 selects rotor A, [6]=1 selects rotor B, [5:0] is the entry address
code_in  in  6  table entry data (during load) or plaintext/ciphertext character (during run)
encrypt  in  1  character-valid strobe; one character per cycle
crypt_mode  in  1  0 = encrypt, 1 = decrypt; sampled on the first accepted character
tbl_we  out  1  table write enable
tbl_sel  out  1  0 = rotor A, 1 = rotor B
tbl_addr  out  6  table write address
tbl_data  out  6  table write data
crypt_mode_buf  out  1  latched crypt_mode
shift_accu  out  6  current rotor A step offset
shift_accu_pipe  out  6  shift_accu aligned with pipeline stage 1
pipe_code  out  6  character registered into stage 1
s1_vld  out  1  stage 1 holds a valid character
code_valid  out  1  stage 2 valid; the datapath output is valid this cycle
busy  out  1  high in RUN or DRAIN
tbl_ready  out  1  all 128 table entries written since the last load session started

Behaviour:
- The clock and reset are decided already: one clock, clk; synchronous, active-high reset, srst.
- Reset values:
  - FSM = IDLE.
  - All outputs 0: tbl_we, tbl_sel, tbl_addr, tbl_data, crypt_mode_buf, shift_accu, shift_accu_pipe, pipe_code, s1_vld, code_valid, busy, tbl_ready.
  - Write counter = 0.
- FSM states: IDLE, LOAD, RUN, DRAIN.
- IDLE:
  - load=1 -> LOAD. Write the current entry. Clear shift_accu, write counter and tbl_ready.
  - Else, encrypt=1 and tbl_ready=1 -> RUN. Latch crypt_mode_buf=crypt_mode and accept the character.
  - encrypt=1 with tbl_ready=0 is dropped. State and outputs are unchanged.
- Priority: load and encrypt asserted together in IDLE -> load wins and the character is dropped.
- LOAD:
  - Each load=1 cycle registers tbl_we=1, tbl_sel=load_idx[6], tbl_addr=load_idx[5:0], tbl_data=code_in. The write appears 1 cycle after the strobe.
  - The write counter (8-bit) increments and saturates at 128. tbl_ready sets the cycle the counter reaches 128.
  - load=0 -> IDLE. tbl_we deasserts 1 cycle later.
  - encrypt is ignored in LOAD.
- Duplicate indices are still counted and are not checked.
- RUN:
  - Each encrypt=1 cycle accepts code_in. Next edge: pipe_code=code_in, s1_vld=1, shift_accu_pipe=shift_accu (pre-increment value), shift_accu=shift_accu+1 mod 64.
  - encrypt=0 -> DRAIN; s1_vld goes 0.
  - load is ignored in RUN and DRAIN.
- Pipeline:
  - code_valid(t+1) = s1_vld(t), so latency is 2 cycles from the accept edge to code_valid.
  - Back-to-back characters give a continuous code_valid with no bubbles.
- DRAIN:
  - Waits until s1_vld=0 and code_valid=0, then -> IDLE.
  - encrypt=1 during DRAIN -> back to RUN, accepting the character. crypt_mode_buf is not re-latched.
  - shift_accu is retained across messages. It clears only on srst or on the next IDLE->LOAD.
- Wrap-around: shift_accu 63 + 1 -> 0. No flag.
- crypt_mode_buf holds from the RUN entry until the next IDLE->RUN. crypt_mode changes mid-message are ignored.
- busy = (state==RUN || state==DRAIN), registered.
- Reset mid-operation: srst clears the FSM, the pipeline valids, shift_accu and tbl_ready. In-flight characters are discarded and the tables must be reloaded.

Decomposition:
- Shared package enigma_pkg:
  - CODE_W, TBL_DEPTH.
  - State enum (IDLE/LOAD/RUN/DRAIN).
  - Table-select constants ROTOR_A=0, ROTOR_B=1.
- One sub-module: enigma_shift_pipe. It holds shift_accu, shift_accu_pipe, pipe_code, s1_vld and code_valid, driven by an accept pulse and a clear pulse from the FSM.
- The FSM and the load path stay in the top level.

Test Plan:
- Reset, then load idx 0..127 with code_in = idx ^ 6'h2A -> tbl_we each following cycle with matching sel/addr/data; tbl_ready=1 one cycle after the 128th write; shift_accu=0.
- After load, 5 back-to-back characters with crypt_mode=0 -> code_valid high for 5 cycles starting 2 cycles after the first accept; shift_accu_pipe = 0,1,2,3,4 alongside s1_vld; final shift_accu=5; crypt_mode_buf=0.
- 66 characters streamed -> shift_accu wraps 63->0->1; shift_accu_pipe shows 63 then 0; no bubble in code_valid.
- encrypt before any load, and load+encrypt together in IDLE -> character dropped, busy stays 0, write performed; crypt_mode toggled mid-message -> crypt_mode_buf unchanged.
- Gap of 1 cycle in encrypt (RUN->DRAIN->RUN) -> code_valid shows one bubble; shift_accu continues without reset. Second message after IDLE with crypt_mode=1 -> crypt_mode_buf=1.
- srst asserted while s1_vld=1 and code_valid=1 -> next cycle all outputs 0, state IDLE, tbl_ready=0; subsequent encrypt is ignored until a full reload.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma rotor sequencer.
// Holds character/table geometry, the control FSM encoding and the rotor-select codes.
package enigma_pkg;

    localparam int CODE_W     = 6;
    localparam int TBL_DEPTH  = 64;
    localparam int PIPE_DEPTH = 2;
    localparam int IDX_W      = CODE_W + 1;
    localparam int CNT_W      = 8;

    // Two rotor tables of TBL_DEPTH entries each must be written before running.
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(2 * TBL_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CODE_W-1:0] CODE_ONE = CODE_W'(1);

    localparam logic ROTOR_A = 1'b0;
    localparam logic ROTOR_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= CNT_FULL) ? CNT_FULL : v + CNT_ONE;
    endfunction

endpackage

// File: rtl/enigma_shift_pipe.sv
// Rotor step offset and the character pipeline feeding the rotor lookups.
// An accept pulse advances the offset and launches a character; clear zeroes the offset.
module enigma_shift_pipe
    import enigma_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic              accept,
    input  logic              clear,
    input  logic [CODE_W-1:0] code_in,
    output logic [CODE_W-1:0] shift_accu,
    output logic [CODE_W-1:0] shift_accu_pipe,
    output logic [CODE_W-1:0] pipe_code,
    output logic              s1_vld,
    output logic              code_valid
);

    logic [CODE_W-1:0]     shift_accu_q, shift_accu_d;
    logic [CODE_W-1:0]     shift_accu_pipe_q, shift_accu_pipe_d;
    logic [CODE_W-1:0]     pipe_code_q, pipe_code_d;
    logic [PIPE_DEPTH-1:0] vld_q, vld_d;

    // Valid bits march one stage per cycle; stage 0 is loaded by the accept pulse.
    generate
        for (genvar gi = 0; gi < PIPE_DEPTH; gi++) begin : g_vld
            if (gi == 0) begin : g_head
                assign vld_d[gi] = accept;
            end else begin : g_tail
                assign vld_d[gi] = vld_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        shift_accu_d      = shift_accu_q;
        shift_accu_pipe_d = shift_accu_pipe_q;
        pipe_code_d       = pipe_code_q;
        if (accept) begin
            pipe_code_d       = code_in;
            shift_accu_pipe_d = shift_accu_q;
            shift_accu_d      = shift_accu_q + CODE_ONE;
        end
        if (clear) begin
            shift_accu_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            shift_accu_q      <= '0;
            shift_accu_pipe_q <= '0;
            pipe_code_q       <= '0;
            vld_q             <= '0;
        end else begin
            shift_accu_q      <= shift_accu_d;
            shift_accu_pipe_q <= shift_accu_pipe_d;
            pipe_code_q       <= pipe_code_d;
            vld_q             <= vld_d;
        end
    end

    assign shift_accu      = shift_accu_q;
    assign shift_accu_pipe = shift_accu_pipe_q;
    assign pipe_code       = pipe_code_q;
    assign s1_vld          = vld_q[0];
    assign code_valid      = vld_q[PIPE_DEPTH-1];

endmodule

// File: rtl/enigma_rotor_ctrl.sv
// Enigma rotor sequencer: serial rotor-table loading plus run/drain control
// of the character pipeline held in enigma_shift_pipe.
module enigma_rotor_ctrl
    import enigma_pkg::*;
(
    input  logic              clk,
    input  logic              srst,
    input  logic              load,
    input  logic [IDX_W-1:0]  load_idx,
    input  logic [CODE_W-1:0] code_in,
    input  logic              encrypt,
    input  logic              crypt_mode,
    output logic              tbl_we,
    output logic              tbl_sel,
    output logic [CODE_W-1:0] tbl_addr,
    output logic [CODE_W-1:0] tbl_data,
    output logic              crypt_mode_buf,
    output logic [CODE_W-1:0] shift_accu,
    output logic [CODE_W-1:0] shift_accu_pipe,
    output logic [CODE_W-1:0] pipe_code,
    output logic              s1_vld,
    output logic              code_valid,
    output logic              busy,
    output logic              tbl_ready
);

    state_t            state_q, state_d;
    logic              tbl_we_q, tbl_we_d;
    logic              tbl_sel_q, tbl_sel_d;
    logic [CODE_W-1:0] tbl_addr_q, tbl_addr_d;
    logic [CODE_W-1:0] tbl_data_q, tbl_data_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              tbl_ready_q, tbl_ready_d;
    logic              crypt_mode_buf_q, crypt_mode_buf_d;
    logic              busy_q, busy_d;
    logic              accept;
    logic              clear;
    logic              do_write;

    always_comb begin
        state_d          = state_q;
        tbl_we_d         = 1'b0;
        tbl_sel_d        = tbl_sel_q;
        tbl_addr_d       = tbl_addr_q;
        tbl_data_d       = tbl_data_q;
        wr_cnt_d         = wr_cnt_q;
        tbl_ready_d      = tbl_ready_q;
        crypt_mode_buf_d = crypt_mode_buf_q;
        accept           = 1'b0;
        clear            = 1'b0;
        do_write         = 1'b0;

        unique case (state_q)
            IDLE: begin
                // load outranks encrypt; a character offered alongside it is dropped.
                if (load) begin
                    state_d     = LOAD;
                    do_write    = 1'b1;
                    clear       = 1'b1;
                    wr_cnt_d    = CNT_ONE;
                    tbl_ready_d = 1'b0;
                end else if (encrypt && tbl_ready_q) begin
                    state_d          = RUN;
                    crypt_mode_buf_d = crypt_mode;
                    accept           = 1'b1;
                end
            end
            LOAD: begin
                if (load) begin
                    do_write    = 1'b1;
                    wr_cnt_d    = sat_inc(wr_cnt_q);
                    tbl_ready_d = tbl_ready_q | (wr_cnt_d == CNT_FULL);
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (encrypt) begin
                    accept = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // A new character resumes the message without re-latching crypt_mode.
                if (encrypt) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end else if (!s1_vld && !code_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_write) begin
            tbl_we_d   = 1'b1;
            tbl_sel_d  = load_idx[IDX_W-1] ? ROTOR_B : ROTOR_A;
            tbl_addr_d = load_idx[CODE_W-1:0];
            tbl_data_d = code_in;
        end

        busy_d = (state_d == RUN) || (state_d == DRAIN);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q          <= IDLE;
            tbl_we_q         <= 1'b0;
            tbl_sel_q        <= 1'b0;
            tbl_addr_q       <= '0;
            tbl_data_q       <= '0;
            wr_cnt_q         <= '0;
            tbl_ready_q      <= 1'b0;
            crypt_mode_buf_q <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            tbl_we_q         <= tbl_we_d;
            tbl_sel_q        <= tbl_sel_d;
            tbl_addr_q       <= tbl_addr_d;
            tbl_data_q       <= tbl_data_d;
            wr_cnt_q         <= wr_cnt_d;
            tbl_ready_q      <= tbl_ready_d;
            crypt_mode_buf_q <= crypt_mode_buf_d;
            busy_q           <= busy_d;
        end
    end

    enigma_shift_pipe u_shift_pipe (
        .clk             (clk),
        .srst            (srst),
        .accept          (accept),
        .clear           (clear),
        .code_in         (code_in),
        .shift_accu      (shift_accu),
        .shift_accu_pipe (shift_accu_pipe),
        .pipe_code       (pipe_code),
        .s1_vld          (s1_vld),
        .code_valid      (code_valid)
    );

    assign tbl_we         = tbl_we_q;
    assign tbl_sel        = tbl_sel_q;
    assign tbl_addr       = tbl_addr_q;
    assign tbl_data       = tbl_data_q;
    assign tbl_ready      = tbl_ready_q;
    assign crypt_mode_buf = crypt_mode_buf_q;
    assign busy           = busy_q;

endmodule
